// File: rtl/pool_ifm_reader_cu.sv
// -----------------------------------------------------------------------------
// pool_ifm_reader_cu
// Consumer-side control unit for a pooled IFM ping-pong memory set. It answers
// the pool stage's start/end handshake, reads one pooled map (all units at the
// same address) out of the current bank set and streams the words downstream
// over valid/ready. A 2-entry skid buffer absorbs the 1-cycle memory latency so
// backpressure never drops or duplicates a pixel.
//
// Ports
//   clk                       rising-edge clock
//   reset                     synchronous, active-low reset
//   start_from_previous       1-cycle pulse: a full map set is ready
//   end_to_previous           high while a new map set can be accepted
//   ifm_enable_read_current   memory read enable (combinational issue)
//   ifm_address_read_current  memory read address
//   ifm_sel_current           bank set being read
//   ifm_data_in               read data, valid the cycle after the enable
//   pixel_valid/pixel_ready   downstream handshake
//   pixel_data                pixel word, unit 0 in the LSBs
//   pixel_row_end             head pixel is the last column of a row
//   pixel_last                head pixel is the last pixel of the map
// -----------------------------------------------------------------------------
module pool_ifm_reader_cu #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 7,
    parameter int IFM_DEPTH        = 3,
    parameter int NUMBER_OF_UNITS  = 3,
    parameter int NUMBER_OF_BANKS  = IFM_DEPTH / NUMBER_OF_UNITS + 1,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_from_previous,
    output logic                                  end_to_previous,
    output logic                                  ifm_enable_read_current,
    output logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_read_current,
    output logic [$clog2(NUMBER_OF_BANKS)-1:0]    ifm_sel_current,
    input  logic [DATA_WIDTH*NUMBER_OF_UNITS-1:0] ifm_data_in,
    output logic                                  pixel_valid,
    input  logic                                  pixel_ready,
    output logic [DATA_WIDTH*NUMBER_OF_UNITS-1:0] pixel_data,
    output logic                                  pixel_row_end,
    output logic                                  pixel_last
);

    localparam int WORD_W = DATA_WIDTH * NUMBER_OF_UNITS;
    localparam int SEL_W  = $clog2(NUMBER_OF_BANKS);
    localparam int COL_W  = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;

    localparam logic [ADDRESS_SIZE_IFM-1:0] ADDR_LAST = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);
    localparam logic [COL_W-1:0]            COL_LAST  = COL_W'(IFM_SIZE - 1);
    localparam logic [SEL_W-1:0]            SEL_LAST  = SEL_W'(NUMBER_OF_BANKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic              last;
        logic              row_end;
        logic [WORD_W-1:0] data;
    } entry_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [ADDRESS_SIZE_IFM-1:0] r_addr;
    logic [COL_W-1:0]            r_col;
    logic [SEL_W-1:0]            r_sel;

    // Tags travel alongside the outstanding read so they line up with its data.
    logic                        r_inflight;
    logic                        r_inflight_row_end;
    logic                        r_inflight_last;

    // Entry 0 is always the head; the buffer compacts on pop.
    entry_t                      r_fifo [2];
    logic [1:0]                  r_occ;

    logic                        w_pop;
    logic                        w_push;
    logic                        w_issue;
    logic                        w_done;
    logic [1:0]                  w_pending;
    entry_t                      w_new;

    assign pixel_valid = (r_occ != 2'd0);
    assign w_pop       = pixel_valid & pixel_ready;
    assign w_push      = r_inflight;
    assign w_pending   = r_occ + {1'b0, r_inflight};

    // A pop in the same cycle frees a slot, so issue can continue at full rate.
    assign w_issue     = (r_state == S_READ) & ((w_pending < 2'd2) | w_pop);
    assign w_new       = {r_inflight_last, r_inflight_row_end, ifm_data_in};

    // The map is done when its last pixel leaves and nothing is behind it.
    assign w_done      = w_pop & r_fifo[0].last & (r_occ == 2'd1) & ~r_inflight;

    assign ifm_enable_read_current  = w_issue;
    assign ifm_address_read_current = r_addr;
    assign ifm_sel_current          = r_sel;
    assign pixel_data               = r_fifo[0].data;
    assign pixel_row_end            = pixel_valid & r_fifo[0].row_end;
    assign pixel_last               = pixel_valid & r_fifo[0].last;

    always_comb begin
        w_state_next    = r_state;
        end_to_previous = 1'b0;
        case (r_state)
            S_IDLE: begin
                end_to_previous = 1'b1;
                if (start_from_previous) w_state_next = S_READ;
            end
            S_READ: begin
                if (w_issue && (r_addr == ADDR_LAST)) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_done) w_state_next = S_FINISH;
            end
            S_FINISH: begin
                end_to_previous = 1'b1;
                if (start_from_previous) w_state_next = S_READ;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_addr             <= '0;
            r_col              <= '0;
            r_sel              <= '0;
            r_inflight         <= 1'b0;
            r_inflight_row_end <= 1'b0;
            r_inflight_last    <= 1'b0;
            r_occ              <= '0;
            r_fifo[0]          <= '0;
            r_fifo[1]          <= '0;
        end else begin
            r_state            <= w_state_next;
            r_inflight         <= w_issue;
            r_inflight_row_end <= (r_col == COL_LAST);
            r_inflight_last    <= (r_addr == ADDR_LAST);

            if (w_issue) begin
                if (r_addr == ADDR_LAST) r_addr <= '0;
                else                     r_addr <= r_addr + 1'b1;
                if (r_col == COL_LAST || r_addr == ADDR_LAST) r_col <= '0;
                else                                          r_col <= r_col + 1'b1;
            end

            if (r_state == S_DRAIN && w_state_next == S_FINISH) begin
                if (r_sel == SEL_LAST) r_sel <= '0;
                else                   r_sel <= r_sel + 1'b1;
            end

            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};

            // Pop shifts entry 1 forward; a simultaneous push lands in the
            // slot that is free after the shift (later assignment wins).
            if (w_pop) r_fifo[0] <= r_fifo[1];
            if (w_push) begin
                if (w_pop) begin
                    if (r_occ == 2'd1) r_fifo[0] <= w_new;
                    else               r_fifo[1] <= w_new;
                end else begin
                    if (r_occ == 2'd0) r_fifo[0] <= w_new;
                    else               r_fifo[1] <= w_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_ifm_reader_cu.sv
// -----------------------------------------------------------------------------
// tb_pool_ifm_reader_cu
// Drives pool_ifm_reader_cu against a random-content bank memory with 1-cycle
// read latency. Expected pixel streams come from the map definition itself:
// pixel k of a map is mem[bank][k], row_end when k is the last column, last
// when k is the final pixel; banks rotate once per completed map.
// -----------------------------------------------------------------------------
module tb_pool_ifm_reader_cu;

    localparam int DW    = 32;
    localparam int SZ    = 7;
    localparam int DEPTH = 3;
    localparam int NU    = 3;
    localparam int NB    = DEPTH / NU + 1;
    localparam int AW    = $clog2(SZ * SZ);
    localparam int SW    = $clog2(NB);
    localparam int WW    = DW * NU;
    localparam int NPIX  = SZ * SZ;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_from_previous = 1'b0;
    logic          pixel_ready = 1'b0;
    logic          end_to_previous;
    logic          ifm_enable_read_current;
    logic [AW-1:0] ifm_address_read_current;
    logic [SW-1:0] ifm_sel_current;
    logic [WW-1:0] ifm_data_in;
    logic          pixel_valid;
    logic [WW-1:0] pixel_data;
    logic          pixel_row_end;
    logic          pixel_last;

    pool_ifm_reader_cu #(
        .DATA_WIDTH      (DW),
        .IFM_SIZE        (SZ),
        .IFM_DEPTH       (DEPTH),
        .NUMBER_OF_UNITS (NU),
        .NUMBER_OF_BANKS (NB),
        .ADDRESS_SIZE_IFM(AW)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start_from_previous     (start_from_previous),
        .end_to_previous         (end_to_previous),
        .ifm_enable_read_current (ifm_enable_read_current),
        .ifm_address_read_current(ifm_address_read_current),
        .ifm_sel_current         (ifm_sel_current),
        .ifm_data_in             (ifm_data_in),
        .pixel_valid             (pixel_valid),
        .pixel_ready             (pixel_ready),
        .pixel_data              (pixel_data),
        .pixel_row_end           (pixel_row_end),
        .pixel_last              (pixel_last)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] mem [NB][NPIX];

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < (WW + 31) / 32; i++) w = (w << 32) | WW'($urandom);
        return w;
    endfunction

    // Synchronous-read memory; garbage when not enabled so stray captures show.
    always @(posedge clk)
        ifm_data_in <= ifm_enable_read_current ?
                       mem[ifm_sel_current][ifm_address_read_current] : rand_word();

    int vectors = 0;
    int miscompares = 0;
    int exp_bank = 0;

    int            cyc;
    int            first_valid;
    int            n_out;
    int            end_high_cnt;
    int            iss_addr [$];
    int            iss_sel  [$];
    int            iss_cyc  [$];
    logic [WW-1:0] got_data [$];
    logic          got_re   [$];
    logic          got_last [$];

    logic          s_en, s_valid, s_end, s_re, s_last;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_sel;
    logic [WW-1:0] s_data;

    task automatic clear_log();
        cyc = 0;
        first_valid = -1;
        end_high_cnt = 0;
        iss_addr.delete(); iss_sel.delete(); iss_cyc.delete();
        got_data.delete(); got_re.delete(); got_last.delete();
    endtask

    // One clock: drive inputs, sample on the falling edge, log issues/pops.
    task automatic cycle(input logic rdy, input logic st);
        logic pop;
        pixel_ready = rdy;
        start_from_previous = st;
        @(negedge clk);
        s_en = ifm_enable_read_current; s_addr = ifm_address_read_current;
        s_sel = ifm_sel_current; s_valid = pixel_valid; s_data = pixel_data;
        s_re = pixel_row_end; s_last = pixel_last; s_end = end_to_previous;
        if (!reset) begin
            n_out = 0;
        end else begin
            pop = s_valid & pixel_ready;
            if (s_en === 1'b1) begin
                iss_addr.push_back(int'(s_addr));
                iss_sel.push_back(int'(s_sel));
                iss_cyc.push_back(cyc);
            end
            if (pop === 1'b1) begin
                got_data.push_back(s_data); got_re.push_back(s_re); got_last.push_back(s_last);
            end
            if (s_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (s_end === 1'b1) end_high_cnt++;
            n_out = n_out + ((s_en === 1'b1) ? 1 : 0) - ((pop === 1'b1) ? 1 : 0);
            vectors++;
            if (n_out > 2 || n_out < 0) begin
                miscompares++;
                $display("FAIL outstanding cyc=%0d got=%0d want<=2", cyc, n_out);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        start_from_previous = 1'b0;
    endtask

    task automatic run_pixels(input int n, input int duty, input int budget);
        int k = 0;
        while (got_data.size() < n && k < budget) begin
            cycle(($urandom_range(0, 99) < duty) ? 1'b1 : 1'b0, 1'b0);
            k++;
        end
    endtask

    task automatic next_bank();
        exp_bank = (exp_bank + 1) % NB;
    endtask

    task automatic test_reset();
        clear_log();
        reset = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        vectors++;
        if (s_valid !== 1'b0 || s_end !== 1'b1 || s_en !== 1'b0 || s_addr !== '0 ||
            s_sel !== '0 || s_re !== 1'b0 || s_last !== 1'b0 || s_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b end=%b en=%b a=%0d sel=%0d re=%b last=%b d=%h want 0 1 0 0 0 0 0 0",
                     s_valid, s_end, s_en, s_addr, s_sel, s_re, s_last, s_data);
        end
        reset = 1'b1;
        cycle(1'b1, 1'b0);
        vectors++;
        if (s_valid !== 1'b0 || s_end !== 1'b1 || s_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got v=%b end=%b en=%b want 0 1 0", s_valid, s_end, s_en);
        end
        exp_bank = 0;
    endtask

    task automatic test_single_map();
        clear_log();
        cycle(1'b1, 1'b1);
        run_pixels(NPIX, 100, 200);
        vectors++;
        if (iss_addr.size() != NPIX) begin
            miscompares++;
            $display("FAIL single_issue_count got=%0d want=%0d", iss_addr.size(), NPIX);
        end
        for (int k = 0; k < iss_addr.size() && k < NPIX; k++) begin
            vectors++;
            if (iss_addr[k] != k || iss_sel[k] != exp_bank || iss_cyc[k] != 1 + k) begin
                miscompares++;
                $display("FAIL single_issue[%0d] got a=%0d sel=%0d cyc=%0d want a=%0d sel=%0d cyc=%0d",
                         k, iss_addr[k], iss_sel[k], iss_cyc[k], k, exp_bank, 1 + k);
            end
        end
        // Data returns the cycle after the enable and is registered into the buffer.
        vectors++;
        if (first_valid != 3) begin
            miscompares++;
            $display("FAIL single_first_valid got cyc=%0d want cyc=3", first_valid);
        end
        vectors++;
        if (got_data.size() != NPIX) begin
            miscompares++;
            $display("FAIL single_pixel_count got=%0d want=%0d", got_data.size(), NPIX);
        end
        for (int k = 0; k < got_data.size() && k < NPIX; k++) begin
            vectors++;
            if (got_data[k] !== mem[exp_bank][k] || got_re[k] !== (k % SZ == SZ - 1) ||
                got_last[k] !== (k == NPIX - 1)) begin
                miscompares++;
                $display("FAIL single_pix[%0d] got d=%h re=%b last=%b want d=%h re=%b last=%b",
                         k, got_data[k], got_re[k], got_last[k], mem[exp_bank][k],
                         (k % SZ == SZ - 1), (k == NPIX - 1));
            end
        end
        vectors++;
        if (end_high_cnt != 1) begin
            miscompares++;
            $display("FAIL single_end_low got high_cycles=%0d want=1", end_high_cnt);
        end
        next_bank();
        cycle(1'b1, 1'b0);
        vectors++;
        if (s_end !== 1'b1 || int'(s_sel) != exp_bank || s_en !== 1'b0) begin
            miscompares++;
            $display("FAIL single_finish got end=%b sel=%0d en=%b want 1 %0d 0", s_end, s_sel, s_en, exp_bank);
        end
    endtask

    task automatic test_stall();
        clear_log();
        cycle(1'b1, 1'b1);
        run_pixels(5, 100, 100);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            vectors++;
            if (s_en !== 1'b0 || s_valid !== 1'b1 || s_data !== mem[exp_bank][5]) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got en=%b v=%b d=%h want 0 1 %h",
                         i, s_en, s_valid, s_data, mem[exp_bank][5]);
            end
        end
        vectors++;
        if (n_out != 2 || got_data.size() != 5) begin
            miscompares++;
            $display("FAIL stall_outstanding got out=%0d popped=%0d want 2 5", n_out, got_data.size());
        end
        run_pixels(NPIX, 100, 200);
        vectors++;
        if (iss_addr.size() != NPIX || got_data.size() != NPIX) begin
            miscompares++;
            $display("FAIL stall_counts got issues=%0d pixels=%0d want %0d %0d",
                     iss_addr.size(), got_data.size(), NPIX, NPIX);
        end
        for (int k = 0; k < got_data.size() && k < NPIX; k++) begin
            vectors++;
            if (got_data[k] !== mem[exp_bank][k] || got_re[k] !== (k % SZ == SZ - 1) ||
                got_last[k] !== (k == NPIX - 1)) begin
                miscompares++;
                $display("FAIL stall_pix[%0d] got d=%h re=%b last=%b want d=%h", k, got_data[k],
                         got_re[k], got_last[k], mem[exp_bank][k]);
            end
        end
        next_bank();
        cycle(1'b1, 1'b0);
    endtask

    task automatic test_random_ready();
        for (int m = 0; m < 3; m++) begin
            clear_log();
            cycle(1'b1, 1'b1);
            vectors++;
            if (int'(s_sel) != exp_bank) begin
                miscompares++;
                $display("FAIL rand_sel_map%0d got=%0d want=%0d", m, s_sel, exp_bank);
            end
            run_pixels(NPIX, 30, 3000);
            vectors++;
            if (got_data.size() != NPIX) begin
                miscompares++;
                $display("FAIL rand_count_map%0d got=%0d want=%0d", m, got_data.size(), NPIX);
            end
            for (int k = 0; k < got_data.size() && k < NPIX; k++) begin
                vectors++;
                if (got_data[k] !== mem[exp_bank][k] || got_re[k] !== (k % SZ == SZ - 1) ||
                    got_last[k] !== (k == NPIX - 1)) begin
                    miscompares++;
                    $display("FAIL rand_pix_map%0d[%0d] got d=%h re=%b last=%b want d=%h",
                             m, k, got_data[k], got_re[k], got_last[k], mem[exp_bank][k]);
                end
            end
            next_bank();
            cycle(1'b0, 1'b0);
        end
        vectors++;
        if (int'(s_sel) != exp_bank) begin
            miscompares++;
            $display("FAIL rand_sel_final got=%0d want=%0d", s_sel, exp_bank);
        end
    endtask

    task automatic test_start_during_read();
        clear_log();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        run_pixels(NPIX, 100, 200);
        vectors++;
        if (iss_addr.size() != NPIX || got_data.size() != NPIX) begin
            miscompares++;
            $display("FAIL sdr_counts got issues=%0d pixels=%0d want %0d %0d",
                     iss_addr.size(), got_data.size(), NPIX, NPIX);
        end
        for (int k = 0; k < iss_addr.size() && k < NPIX; k++) begin
            vectors++;
            if (iss_addr[k] != k || iss_cyc[k] != 1 + k) begin
                miscompares++;
                $display("FAIL sdr_issue[%0d] got a=%0d cyc=%0d want a=%0d cyc=%0d",
                         k, iss_addr[k], iss_cyc[k], k, 1 + k);
            end
        end
        for (int k = 0; k < got_data.size() && k < NPIX; k++) begin
            vectors++;
            if (got_data[k] !== mem[exp_bank][k] || got_last[k] !== (k == NPIX - 1)) begin
                miscompares++;
                $display("FAIL sdr_pix[%0d] got d=%h last=%b want d=%h", k, got_data[k],
                         got_last[k], mem[exp_bank][k]);
            end
        end
        next_bank();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0);
            vectors++;
            if (s_en !== 1'b0 || s_end !== 1'b1 || int'(s_sel) != exp_bank) begin
                miscompares++;
                $display("FAIL sdr_no_requeue[%0d] got en=%b end=%b sel=%0d want 0 1 %0d",
                         i, s_en, s_end, s_sel, exp_bank);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        cycle(1'b1, 1'b1);
        run_pixels(NPIX, 100, 200);
        vectors++;
        if (got_data.size() != NPIX || got_data[NPIX-1] !== mem[exp_bank][NPIX-1]) begin
            miscompares++;
            $display("FAIL b2b_first_map got n=%0d want %0d", got_data.size(), NPIX);
        end
        next_bank();
        clear_log();
        cycle(1'b1, 1'b1);
        vectors++;
        if (s_end !== 1'b1 || int'(s_sel) != exp_bank) begin
            miscompares++;
            $display("FAIL b2b_finish_cycle got end=%b sel=%0d want 1 %0d", s_end, s_sel, exp_bank);
        end
        cycle(1'b1, 1'b0);
        vectors++;
        if (s_en !== 1'b1 || s_addr !== '0 || int'(s_sel) != exp_bank || s_end !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_reenter got en=%b a=%0d sel=%0d end=%b want 1 0 %0d 0",
                     s_en, s_addr, s_sel, s_end, exp_bank);
        end
        run_pixels(NPIX, 100, 200);
        vectors++;
        if (got_data.size() != NPIX) begin
            miscompares++;
            $display("FAIL b2b_count got=%0d want=%0d", got_data.size(), NPIX);
        end
        for (int k = 0; k < got_data.size() && k < NPIX; k++) begin
            vectors++;
            if (got_data[k] !== mem[exp_bank][k] || got_re[k] !== (k % SZ == SZ - 1)) begin
                miscompares++;
                $display("FAIL b2b_pix[%0d] got d=%h re=%b want d=%h", k, got_data[k], got_re[k],
                         mem[exp_bank][k]);
            end
        end
        next_bank();
    endtask

    task automatic test_reset_mid_map();
        clear_log();
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1, 1'b0);
            if (iss_addr.size() > 0 && iss_addr[$] == 19) break;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        vectors++;
        if (n_out != 2 || s_addr !== AW'(20) || s_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_setup got out=%0d a=%0d en=%b want 2 20 0", n_out, s_addr, s_en);
        end
        reset = 1'b0;
        cycle(1'b0, 1'b0);
        reset = 1'b1;
        cycle(1'b0, 1'b0);
        exp_bank = 0;
        vectors++;
        if (s_valid !== 1'b0 || s_end !== 1'b1 || s_addr !== '0 || s_sel !== '0 || s_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid got v=%b end=%b a=%0d sel=%0d en=%b want 0 1 0 0 0",
                     s_valid, s_end, s_addr, s_sel, s_en);
        end
        clear_log();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        vectors++;
        if (s_en !== 1'b1 || s_addr !== '0 || s_sel !== '0) begin
            miscompares++;
            $display("FAIL rst_restart got en=%b a=%0d sel=%0d want 1 0 0", s_en, s_addr, s_sel);
        end
        run_pixels(NPIX, 100, 200);
        vectors++;
        if (got_data.size() != NPIX) begin
            miscompares++;
            $display("FAIL rst_count got=%0d want=%0d", got_data.size(), NPIX);
        end
        for (int k = 0; k < got_data.size() && k < NPIX; k++) begin
            vectors++;
            if (got_data[k] !== mem[exp_bank][k] || got_last[k] !== (k == NPIX - 1)) begin
                miscompares++;
                $display("FAIL rst_pix[%0d] got d=%h last=%b want d=%h", k, got_data[k],
                         got_last[k], mem[exp_bank][k]);
            end
        end
    endtask

    initial begin
        n_out = 0;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < NPIX; a++) mem[b][a] = rand_word();
        #1;
        test_reset();
        test_single_map();
        test_stall();
        test_random_ready();
        test_start_during_read();
        test_back_to_back();
        test_reset_mid_map();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
